// File: rtl/picomem_pkg.sv
// Shared types and constants for the picomem_ctrl memory responder.
// Optional range checking is enabled by defining PICOMEM_RANGE_CHK_EN.
package picomem_pkg;

    // Request sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Read data returned for out-of-range reads
    localparam logic [31:0] PICOMEM_BAD_DATA = 32'hDEAD_BEEF;

    // Width of the wait-state counter (WAIT_STATES up to 15)
    localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/picomem_array.sv
// Word-organised RAM with byte write enables: writes commit on the rising
// edge, the read port is asynchronous so the controller can capture the
// pre-write word on the same edge that commits a write.
module picomem_array #(
    parameter int unsigned WORDS  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [WORDS];

    // Byte-strobed write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/picomem_ctrl.sv
// picomem_ctrl: picorv32 native-interface memory responder with wait states,
// base address and byte-strobed writes. Defining PICOMEM_RANGE_CHK_EN adds
// out-of-range detection (suppressed writes, DEAD_BEEF reads, sticky err).
module picomem_ctrl
    import picomem_pkg::*;
#(
    parameter int unsigned WORDS       = 32,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int unsigned       IDX_W     = $clog2(WORDS);
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_STATES);

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         instr_cnt_q, instr_cnt_d;

    logic [31:0]         acc_addr_c, acc_wdata_c;
    logic [3:0]          acc_wstrb_c;
    logic [31:0]         offset_c;
    logic [IDX_W-1:0]    idx_c;
    logic                in_range_c;
    logic                access_c;
    logic [3:0]          we_c;
    logic [3:0]          ram_we_c;
    logic [31:0]         arr_rdata_c;
    logic                unused_c;

    // Zero-wait accesses happen in IDLE straight from the bus; otherwise use the latched request
    assign acc_addr_c  = (state_q == ST_IDLE) ? mem_addr  : addr_q;
    assign acc_wdata_c = (state_q == ST_IDLE) ? mem_wdata : wdata_q;
    assign acc_wstrb_c = (state_q == ST_IDLE) ? mem_wstrb : wstrb_q;

    assign offset_c = acc_addr_c - ADDR_BASE;
    assign idx_c    = offset_c[IDX_W+1:2];

`ifdef PICOMEM_RANGE_CHK_EN
    assign in_range_c = (offset_c[31:IDX_W+2] == '0);
`else
    assign in_range_c = 1'b1;
`endif

    // No write may land while reset is held, even if a request is on the bus
    assign ram_we_c = we_c & {4{~reset}};

    // Instruction-fetch count and dropped address bits are kept for debug visibility only
    assign unused_c = ^{offset_c[1:0], offset_c[31:IDX_W+2], instr_cnt_q};

    picomem_array #(
        .WORDS  (WORDS),
        .ADDR_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (idx_c),
        .wdata (acc_wdata_c),
        .rdata (arr_rdata_c)
    );

    // Next-state, wait counting and access generation
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wcnt_d      = wcnt_q;
        instr_cnt_d = instr_cnt_q;
        rdata_d     = rdata_q;
        access_c    = 1'b0;
        we_c        = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    wcnt_d  = WCNT_INIT;
                    if (mem_instr) begin
                        instr_cnt_d = instr_cnt_q + 32'd1;
                    end
                    if (WAIT_STATES == 0) begin
                        access_c = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!mem_valid) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == WCNT_W'(1)) begin
                    access_c = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (access_c) begin
            rdata_d = in_range_c ? arr_rdata_c : PICOMEM_BAD_DATA;
            we_c    = acc_wstrb_c & {4{in_range_c}};
        end

        ready_d = access_c;
    end

    // Controller state and registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wcnt_q      <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wcnt_q      <= wcnt_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

`ifdef PICOMEM_RANGE_CHK_EN
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    // First out-of-range access sets the sticky flag and records its address
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (access_c && !in_range_c && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = acc_addr_c;
        end
    end

    // Error capture registers, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    assign err      = 1'b0;
    assign err_addr = '0;
`endif

endmodule

// File: tb/tb_picomem_ctrl.sv
// Self-checking bench for picomem_ctrl: directed and random requests checked
// against a word-array reference model of the memory and error capture.
module tb_picomem_ctrl;

    localparam int unsigned WORDS = 32;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned WS    = 3;
`ifdef PICOMEM_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err;
    logic [31:0] err_addr;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] model_mem [WORDS];
    bit          known     [WORDS];
    bit          err_m;
    logic [31:0] err_addr_m;

    picomem_ctrl #(
        .WORDS       (WORDS),
        .ADDR_BASE   (BASE),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err       (err),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete core transaction, checked against the reference model
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rd);
        logic [31:0] off;
        bit          inr;
        int          idx;
        logic [31:0] exp_rd;
        bit          exp_known;
        int          lat;

        off       = addr - BASE;
        inr       = (off < 4 * WORDS);
        idx       = int'((off >> 2) % WORDS);
        exp_rd    = model_mem[idx];
        exp_known = known[idx];
        if (CHK && !inr) begin
            exp_rd    = 32'hDEAD_BEEF;
            exp_known = 1'b1;
        end

        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_instr = 1'($urandom_range(0, 1));

        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) lat = 99;
        check("ready_latency", 32'(lat), 32'(WS + 1));
        rd = mem_rdata;
        if (exp_known) check("rdata", mem_rdata, exp_rd);

        if (wstrb != 4'b0000 && (!CHK || inr)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (wstrb == 4'hF) known[idx] = 1'b1;
        end
        if (CHK && !inr && !err_m) begin
            err_m      = 1'b1;
            err_addr_m = addr;
        end
        check("err", {31'b0, err}, {31'b0, err_m});
        check("err_addr", err_addr, err_addr_m);

        // Core still holds valid through the ready cycle; ready must not repeat
        @(posedge clk);
        #1;
        check("ready_pulse", {31'b0, mem_ready}, 32'h0);
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [3:0]  s;
        int          n;

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        err_m      = 1'b0;
        err_addr_m = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            known[i]     = 1'b0;
            model_mem[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, mem_ready}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Preload every word
        for (int i = 0; i < int'(WORDS); i++) begin
            do_req(BASE + 32'(4 * i), $urandom, 4'hF, rd);
        end

        // Full-word write and readback
        do_req(BASE + 32'h8, 32'h1234_5678, 4'hF, rd);
        do_req(BASE + 32'h8, 32'h0, 4'h0, rd);
        check("word_readback", rd, 32'h1234_5678);

        // Byte strobes
        do_req(BASE + 32'hC, 32'hAABB_CCDD, 4'hF, rd);
        do_req(BASE + 32'hC, 32'h1122_3344, 4'b0101, rd);
        check("strobe_prewrite", rd, 32'hAABB_CCDD);
        do_req(BASE + 32'hC, 32'h0, 4'h0, rd);
        check("strobe_merge", rd, 32'hAA22_CC44);

        // Address just past the array
`ifdef PICOMEM_RANGE_CHK_EN
        do_req(BASE + 32'h80, 32'h0, 4'h0, rd);
        check("oor_rdata", rd, 32'hDEAD_BEEF);
        check("oor_err", {31'b0, err}, 32'h1);
        check("oor_err_addr", err_addr, 32'h0000_1080);
        do_req(BASE + 32'h84, 32'h5555_AAAA, 4'hF, rd);
        check("oor_err_addr_sticky", err_addr, 32'h0000_1080);
        do_req(BASE + 32'h4, 32'h0, 4'h0, rd);
`else
        do_req(BASE + 32'h80, 32'hCAFE_F00D, 4'hF, rd);
        do_req(BASE, 32'h0, 4'h0, rd);
        check("alias_word0", rd, 32'hCAFE_F00D);
        check("alias_err", {31'b0, err}, 32'h0);
`endif

        // Random traffic, including addresses beyond the array
        for (int i = 0; i < 60; i++) begin
            a = BASE + 32'($urandom_range(0, 39) * 4) + 32'($urandom_range(0, 3));
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_req(a, $urandom, s, rd);
        end

        // Reset in the middle of a waited write: no ready, no write, outputs cleared
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h10;
        mem_wdata = ~model_mem[4];
        mem_wstrb = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'b0, mem_ready}, 32'h0);
        check("midrst_rdata", mem_rdata, 32'h0);
        check("midrst_err", {31'b0, err}, 32'h0);
        check("midrst_err_addr", err_addr, 32'h0);
        err_m      = 1'b0;
        err_addr_m = '0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) n++;
        end
        check("midrst_no_ready", 32'(n), 32'h0);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        do_req(BASE + 32'h10, 32'h0, 4'h0, rd);
        do_req(BASE + 32'h14, 32'h0BAD_F00D, 4'hF, rd);
        do_req(BASE + 32'h14, 32'h0, 4'h0, rd);
        check("postrst_readback", rd, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
